// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit processor; drives every datapath strobe.
// Three cycles per instruction; INPUT holds until Enter (plus optional release wait); HALT sticks until Reset.
module control_unit #(
  parameter int OP_W            = 3,
  parameter bit REQUIRE_RELEASE = 1'b1
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [OP_W-1:0] IR,
  input  logic            Aeq0,
  input  logic            Apos,
  input  logic            Enter,
  output logic            PCload,
  output logic            JMPmux,
  output logic            IRload,
  output logic            Meminst,
  output logic            MemWr,
  output logic            Aload,
  output logic            Sub,
  output logic [1:0]      Asel,
  output logic            Halt,
  output logic [3:0]      State
);

  localparam logic [3:0] S_START  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_HALT   = 4'd7;
  localparam logic [3:0] S_LOAD   = 4'd8;
  localparam logic [3:0] S_STORE  = 4'd9;
  localparam logic [3:0] S_ADD    = 4'd10;
  localparam logic [3:0] S_SUB    = 4'd11;
  localparam logic [3:0] S_INPUT  = 4'd12;
  localparam logic [3:0] S_INREL  = 4'd13;
  localparam logic [3:0] S_JZ     = 4'd14;
  localparam logic [3:0] S_JPOS   = 4'd15;

  logic [3:0] state;
  logic [3:0] state_next;

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_START;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_START;
    case (state)
      S_START:  state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (IR)
          OP_W'(0): state_next = S_LOAD;
          OP_W'(1): state_next = S_STORE;
          OP_W'(2): state_next = S_ADD;
          OP_W'(3): state_next = S_SUB;
          OP_W'(4): state_next = S_INPUT;
          OP_W'(5): state_next = S_JZ;
          OP_W'(6): state_next = S_JPOS;
          default:  state_next = S_HALT;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: state_next = S_FETCH;
      S_INPUT: begin
        if (!Enter)               state_next = S_INPUT;
        else if (REQUIRE_RELEASE) state_next = S_INREL;
        else                      state_next = S_FETCH;
      end
      // Waiting for release keeps a held key from loading A on the next INPUT.
      S_INREL:  state_next = Enter ? S_INREL : S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_START;
    endcase
  end

  always_comb begin
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    IRload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = 2'b00;
    Halt    = 1'b0;
    State   = 4'd0;
    if (!Reset) begin
      State = state;
      case (state)
        S_FETCH: begin
          Meminst = 1'b1;
          IRload  = 1'b1;
          PCload  = 1'b1;
        end
        S_LOAD: begin
          Asel  = 2'b10;
          Aload = 1'b1;
        end
        S_STORE: MemWr = 1'b1;
        S_ADD:   Aload = 1'b1;
        S_SUB: begin
          Aload = 1'b1;
          Sub   = 1'b1;
        end
        S_INPUT: begin
          Asel  = 2'b01;
          Aload = Enter;
        end
        S_JZ: begin
          JMPmux = 1'b1;
          PCload = Aeq0;
        end
        S_JPOS: begin
          JMPmux = 1'b1;
          PCload = Apos;
        end
        S_HALT:  Halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: one instance with release wait, one without.
module tb_control_unit;

  logic       Clock = 1'b0;
  logic       Reset, Aeq0, Apos, Enter;
  logic [2:0] IR;

  logic       PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [3:0] State;

  logic       nr_PCload, nr_JMPmux, nr_IRload, nr_Meminst, nr_MemWr, nr_Aload, nr_Sub, nr_Halt;
  logic [1:0] nr_Asel;
  logic [3:0] nr_State;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  control_unit #(.OP_W(3), .REQUIRE_RELEASE(1'b1)) u_dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .PCload(PCload), .JMPmux(JMPmux), .IRload(IRload), .Meminst(Meminst), .MemWr(MemWr),
    .Aload(Aload), .Sub(Sub), .Asel(Asel), .Halt(Halt), .State(State)
  );

  control_unit #(.OP_W(3), .REQUIRE_RELEASE(1'b0)) u_dut_nr (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .PCload(nr_PCload), .JMPmux(nr_JMPmux), .IRload(nr_IRload), .Meminst(nr_Meminst),
    .MemWr(nr_MemWr), .Aload(nr_Aload), .Sub(nr_Sub), .Asel(nr_Asel), .Halt(nr_Halt),
    .State(nr_State)
  );

  // {PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel[1:0], Halt}
  localparam logic [9:0] V_ZERO   = 10'b0000000000;
  localparam logic [9:0] V_FETCH  = 10'b1011000000;
  localparam logic [9:0] V_LOAD   = 10'b0000010100;
  localparam logic [9:0] V_STORE  = 10'b0000100000;
  localparam logic [9:0] V_ADD    = 10'b0000010000;
  localparam logic [9:0] V_SUB    = 10'b0000011000;
  localparam logic [9:0] V_IN_LO  = 10'b0000000010;
  localparam logic [9:0] V_IN_HI  = 10'b0000010010;
  localparam logic [9:0] V_JMP_T  = 10'b1100000000;
  localparam logic [9:0] V_JMP_N  = 10'b0100000000;
  localparam logic [9:0] V_HALT   = 10'b0000000001;

  logic [9:0] outs;
  assign outs = {PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel, Halt};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [9:0] v);
    check({tag, ".state"}, {12'd0, State}, {12'd0, st});
    check({tag, ".outs"}, {6'd0, outs}, {6'd0, v});
  endtask

  // Starts and ends in FETCH with IR set for the next decode.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic [3:0] st,
                           input logic [9:0] v);
    IR = op;
    expect_cycle({tag, ".fetch"}, 4'd1, V_FETCH);
    tick();
    expect_cycle({tag, ".decode"}, 4'd2, V_ZERO);
    tick();
    expect_cycle({tag, ".exec"}, st, v);
    tick();
  endtask

  initial begin
    Reset = 1'b1; IR = 3'b000; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;
    #1;
    expect_cycle("rst0", 4'd0, V_ZERO);
    tick();
    expect_cycle("rst1", 4'd0, V_ZERO);
    tick();
    Reset = 1'b0;
    #1;
    expect_cycle("start", 4'd0, V_ZERO);
    tick();

    run_instr("load",  3'b000, 4'd8,  V_LOAD);
    run_instr("store", 3'b001, 4'd9,  V_STORE);
    run_instr("add",   3'b010, 4'd10, V_ADD);
    run_instr("sub",   3'b011, 4'd11, V_SUB);
    Aeq0 = 1'b1;
    run_instr("jz_t",  3'b101, 4'd14, V_JMP_T);
    Aeq0 = 1'b0;
    run_instr("jz_n",  3'b101, 4'd14, V_JMP_N);
    Apos = 1'b1;
    run_instr("jp_t",  3'b110, 4'd15, V_JMP_T);
    Apos = 1'b0;
    run_instr("jp_n",  3'b110, 4'd15, V_JMP_N);
    expect_cycle("back", 4'd1, V_FETCH);

    // INPUT with a held key
    IR = 3'b100;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_cycle("in_wait", 4'd12, V_IN_LO);
      if (i < 3) tick();
    end
    Enter = 1'b1;
    #1;
    expect_cycle("in_cap", 4'd12, V_IN_HI);
    check("nr.state_cap", {12'd0, nr_State}, 16'd12);
    tick();
    check("nr.fetch", {12'd0, nr_State}, 16'd1);
    expect_cycle("inrel0", 4'd13, V_ZERO);
    tick();
    expect_cycle("inrel1", 4'd13, V_ZERO);
    Enter = 1'b0;
    #1;
    expect_cycle("inrel2", 4'd13, V_ZERO);
    tick();
    expect_cycle("in_done", 4'd1, V_FETCH);

    // Reset during STORE
    IR = 3'b001;
    tick();
    tick();
    expect_cycle("st_mid", 4'd9, V_STORE);
    Reset = 1'b1;
    #1;
    expect_cycle("st_rst", 4'd0, V_ZERO);
    tick();
    Reset = 1'b0;
    #1;
    expect_cycle("st_start", 4'd0, V_ZERO);
    tick();
    expect_cycle("st_fetch", 4'd1, V_FETCH);

    // Reset during INPUT with Enter pressed
    IR = 3'b100;
    tick();
    tick();
    expect_cycle("in_mid", 4'd12, V_IN_LO);
    Reset = 1'b1;
    Enter = 1'b1;
    #1;
    expect_cycle("in_rst", 4'd0, V_ZERO);
    tick();
    Reset = 1'b0;
    Enter = 1'b0;
    #1;
    expect_cycle("in_start", 4'd0, V_ZERO);
    tick();

    // HALT ignores Enter until Reset
    IR = 3'b111;
    expect_cycle("h_fetch", 4'd1, V_FETCH);
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      Enter = i[0];
      #1;
      expect_cycle("halt", 4'd7, V_HALT);
      tick();
    end
    Enter = 1'b0;
    Reset = 1'b1;
    #1;
    expect_cycle("h_rst", 4'd0, V_ZERO);
    tick();
    Reset = 1'b0;
    #1;
    expect_cycle("h_start", 4'd0, V_ZERO);
    tick();
    expect_cycle("h_fetch2", 4'd1, V_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
